center_scale_mc: RTL and testbench
==================================

Name: center_scale_mc

Overview:
- Multi-channel, parametrised successor to the single-channel center/scale stage.
- Computes z = (x - mean[ch]) * inv_std[ch] in fixed point, using a per-channel coefficient register file.
- Fully pipelined with valid/ready backpressure, a per-sample mode select and saturation flagging.
- Sits between the ADC sample mux and the downstream feature/classifier datapath.

Parameters:
- NCH, 4: number of channels; NCH >= 1.
- XW, 21: ADC sample width, unsigned integer.
- MF, 8: fractional bits of mean. Mean is unsigned, XW+MF bits.
- CW, 24: inv_std width, unsigned, Q(CW-CF).CF.
- CF, 16: fractional bits of inv_std.
- ZW, 32: output width, signed, Q(ZW-ZF).ZF.
- ZF, 16: fractional bits of the output.

Ports:
- clk  in  1  rising-edge clock.
- GlobalReset  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- in_x  in  XW  ADC sample.
- in_ch  in  clog2(NCH)  channel index.
- in_mode  in  2  00 bypass, 01 center only, 10 scale only, 11 center and scale.
- cfg_we  in  1  coefficient write strobe.
- cfg_ch  in  clog2(NCH)  channel to write.
- cfg_sel  in  1  0 writes mean, 1 writes inv_std.
- cfg_data  in  32  write data, low XW+MF or CW bits used.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out_z  out  ZW  result.
- out_sat  out  1  out_z was saturated.
- out_ch  out  clog2(NCH)  channel tag.
- out_x  out  XW  raw sample, passed through with the result.

Behaviour:
- Reset, asynchronous while GlobalReset = 0:
  - All pipeline valid bits cleared; out_valid = 0; out_z, out_sat, out_ch, out_x = 0.
  - Every mean[ch] = 0; every inv_std[ch] = 1 << CF (1.0).
- Reset is allowed mid-operation: in-flight samples are dropped and the coefficients return to their reset values.
- Handshake:
  - A sample is accepted when in_valid && in_ready.
  - The output transfers when out_valid && out_ready.
  - Global advance: en = !out_valid || out_ready; in_ready = en. All stages shift only when en = 1.
  - While out_valid = 1 and out_ready = 0, out_z, out_sat, out_ch and out_x hold stable.
- Pipeline: 4 stages, so a sample accepted in cycle N shows out_valid = 1 in cycle N+4 when not stalled. Full throughput is 1 sample per cycle.
  - S1: register in_x, in_ch, in_mode, and snapshot mean[in_ch] and inv_std[in_ch].
  - S2: d = (in_x << MF) - mean, signed, XW+MF+1 bits.
    - Mode 10 or 00: d = in_x << MF.
  - S3: p = d * inv_std, signed, MF+CF fractional bits.
    - Mode 01 or 00: p = d << CF.
  - S4: r = p >>> (MF+CF-ZF). The shift is arithmetic, truncating toward minus infinity.
    - Saturate r to the signed ZW range and set out_sat when clamped.
    - The result is loaded into the output register.
- Coefficients:
  - A cfg write takes effect at the clock edge.
  - A sample accepted in the same cycle as a write to its channel uses the old value.
  - In-flight samples are never affected by later writes, because of the S1 snapshot.
  - cfg writes are accepted on every cycle, including during stalls.
  - cfg_ch >= NCH: the write is ignored.
  - in_ch >= NCH: the sample is processed with reset coefficients (mean 0, inv_std 1.0).
- Boundary cases:
  - A negative d produces a negative out_z.
  - mean > x << MF is legal.
  - inv_std = 0 gives out_z = 0 for modes 10 and 11.
  - Back-to-back samples on alternating channels must not cross-contaminate coefficients.

Decomposition:
- Package cs_pkg:
  - Mode constants MODE_BYP, MODE_CTR, MODE_SCL, MODE_CS.
  - Default widths.
  - Reset constant INV_STD_ONE = 1 << CF.
  - Helper function for saturating the signed ZW result.
- Sub-module cs_coef_rf:
  - Holds NCH x {mean, inv_std} with asynchronous active-low reset.
  - One write port and one combinational read port.
  - Out-of-range reads return reset values.
- The top level holds the 4-stage pipeline and the handshake logic.

Test Plan:
- Reset, then write ch0 mean = 100<<8 and inv_std = 0x8000 (0.5). Send x = 0x7F, mode 11 -> out_z = 0x000D8000 (13.5) at cycle +4, out_sat = 0, out_x = 0x7F, out_ch = 0.
- Mode sweep with x = 9 and ch0 as above:
  - 00 -> out_z = 0x00090000.
  - 01 -> 0xFFA50000 (-91).
  - 10 -> 0x00048000 (4.5).
  - 11 -> 0xFFD28000 (-45.5).
- Saturation: inv_std = 0xFFFFFF, mean = 0, x = 0x1FFFFF, mode 11 -> out_z = 0x7FFFFFFF, out_sat = 1.
- Backpressure: stream 8 samples with out_ready low for cycles 3-7 -> in_ready = 0 while stalled, output stays stable, all 8 results arrive in order with none lost or duplicated.
- Coefficient race: write ch1 mean in the same cycle a ch1 sample is accepted -> the result uses the old mean; the next ch1 sample uses the new mean.
- Reset mid-stream: assert GlobalReset = 0 with 3 samples in flight -> out_valid = 0 immediately, coefficients return to reset values, and no stale output appears after release.

Source files
------------

// File: rtl/cs_pkg.sv
// Shared constants, default widths and the saturation helper for center_scale_mc.
package cs_pkg;

    // Default widths (the top-level parameters take these as defaults)
    localparam int NCH_D = 4;
    localparam int XW_D  = 21;
    localparam int MF_D  = 8;
    localparam int CW_D  = 24;
    localparam int CF_D  = 16;
    localparam int ZW_D  = 32;
    localparam int ZF_D  = 16;

    // Per-sample mode select: bit0 = subtract mean, bit1 = multiply by inv_std
    localparam logic [1:0] MODE_BYP = 2'b00;
    localparam logic [1:0] MODE_CTR = 2'b01;
    localparam logic [1:0] MODE_SCL = 2'b10;
    localparam logic [1:0] MODE_CS  = 2'b11;

    // inv_std reset value (1.0) at the default widths
    localparam logic [CW_D-1:0] INV_STD_ONE = CW_D'(1) << CF_D;

    typedef struct packed {
        logic [63:0] val;
        logic        sat;
    } sat_t;

    // Clamp a sign-extended 64-bit value into the signed zw-bit range
    function automatic sat_t sat_signed(input logic signed [63:0] v, input int zw);
        sat_t              res;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi      = (64'sd1 <<< (zw - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (zw - 1));
        res.val = v;
        res.sat = 1'b0;
        if (v > hi) begin
            res.val = hi;
            res.sat = 1'b1;
        end else if (v < lo) begin
            res.val = lo;
            res.sat = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/cs_coef_rf.sv
// Per-channel coefficient store: NCH x {mean, inv_std}, one write port, one
// combinational read port. Out-of-range channels read back the reset values.
module cs_coef_rf
    import cs_pkg::*;
#(
    parameter int NCH = NCH_D,
    parameter int CHW = 2,
    parameter int MW  = XW_D + MF_D,
    parameter int CW  = CW_D,
    parameter int CF  = CF_D
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_we,
    input  logic [CHW-1:0] i_wr_ch,
    input  logic           i_sel,
    input  logic [31:0]    i_data,
    input  logic [CHW-1:0] i_rd_ch,
    output logic [MW-1:0]  o_mean,
    output logic [CW-1:0]  o_inv
);

    localparam logic [CW-1:0] L_ONE = CW'(1) << CF;
    localparam int            L_UB  = (MW > CW) ? MW : CW;

    logic [MW-1:0] r_mean [NCH];
    logic [CW-1:0] r_inv  [NCH];
    logic          w_hit;
    logic          w_unused_data;

    // Data bits above both coefficient widths carry nothing
    assign w_unused_data = &{1'b0, i_data[31:L_UB]};

    // Coefficient writes; a cfg_ch beyond the last channel matches no entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_mean[i] <= '0;
                r_inv[i]  <= L_ONE;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (i_we && (i_wr_ch == CHW'(i))) begin
                    if (i_sel) r_inv[i]  <= i_data[CW-1:0];
                    else       r_mean[i] <= i_data[MW-1:0];
                end
            end
        end
    end

    // Read port: out-of-range channel behaves as mean 0, inv_std 1.0
    always_comb begin
        w_hit  = ({{(32-CHW){1'b0}}, i_rd_ch} < 32'(NCH));
        o_mean = '0;
        o_inv  = L_ONE;
        if (w_hit) begin
            o_mean = r_mean[i_rd_ch];
            o_inv  = r_inv[i_rd_ch];
        end
    end

endmodule

// File: rtl/center_scale_mc.sv
// Multi-channel center/scale stage: z = (x - mean[ch]) * inv_std[ch], 4-stage
// pipeline with one global advance enable driven by the output handshake.
// Handshake: input accepted on in_valid && in_ready, output consumed on
// out_valid && out_ready; in_ready = !out_valid || out_ready and every stage
// shifts only on that enable, so a stalled output holds all its fields.
module center_scale_mc
    import cs_pkg::*;
#(
    parameter int NCH = NCH_D,
    parameter int XW  = XW_D,
    parameter int MF  = MF_D,
    parameter int CW  = CW_D,
    parameter int CF  = CF_D,
    parameter int ZW  = ZW_D,
    parameter int ZF  = ZF_D,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           GlobalReset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [XW-1:0]  in_x,
    input  logic [CHW-1:0] in_ch,
    input  logic [1:0]     in_mode,
    input  logic           cfg_we,
    input  logic [CHW-1:0] cfg_ch,
    input  logic           cfg_sel,
    input  logic [31:0]    cfg_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [ZW-1:0]  out_z,
    output logic           out_sat,
    output logic [CHW-1:0] out_ch,
    output logic [XW-1:0]  out_x
);

    localparam int MW = XW + MF;        // mean width
    localparam int DW = MW + 1;         // signed difference width
    localparam int PW = DW + CW + 1;    // signed product width
    localparam int SH = MF + CF - ZF;   // product-to-output shift

    logic                 w_en;
    logic [MW-1:0]        w_mean;
    logic [CW-1:0]        w_inv;

    // Stage 1: sample and coefficient snapshot
    logic                 r_s1_v;
    logic [XW-1:0]        r_s1_x;
    logic [CHW-1:0]       r_s1_ch;
    logic [1:0]           r_s1_mode;
    logic [MW-1:0]        r_s1_mean;
    logic [CW-1:0]        r_s1_inv;
    // Stage 2: difference
    logic                 r_s2_v;
    logic [XW-1:0]        r_s2_x;
    logic [CHW-1:0]       r_s2_ch;
    logic [1:0]           r_s2_mode;
    logic signed [DW-1:0] r_s2_d;
    logic [CW-1:0]        r_s2_inv;
    // Stage 3: product
    logic                 r_s3_v;
    logic [XW-1:0]        r_s3_x;
    logic [CHW-1:0]       r_s3_ch;
    logic signed [PW-1:0] r_s3_p;

    logic signed [DW-1:0] w_x_sh;
    logic signed [DW-1:0] w_s2_d;
    logic signed [PW-1:0] w_d_ext;
    logic signed [PW-1:0] w_inv_ext;
    logic signed [PW-1:0] w_s3_p;
    logic signed [PW-1:0] w_s4_r;
    sat_t                 w_sat;
    logic                 w_unused_sat;

    assign w_en     = !out_valid || out_ready;
    assign in_ready = w_en;

    cs_coef_rf #(
        .NCH (NCH),
        .CHW (CHW),
        .MW  (MW),
        .CW  (CW),
        .CF  (CF)
    ) u_coef_rf (
        .i_clk   (clk),
        .i_rst_n (GlobalReset),
        .i_we    (cfg_we),
        .i_wr_ch (cfg_ch),
        .i_sel   (cfg_sel),
        .i_data  (cfg_data),
        .i_rd_ch (in_ch),
        .o_mean  (w_mean),
        .o_inv   (w_inv)
    );

    // Difference: x aligned to the mean's fraction, mean subtracted when centering
    always_comb begin
        w_x_sh = $signed({1'b0, r_s1_x, {MF{1'b0}}});
        w_s2_d = w_x_sh;
        if (r_s1_mode == MODE_CTR || r_s1_mode == MODE_CS)
            w_s2_d = w_x_sh - $signed({1'b0, r_s1_mean});
    end

    // Product: signed multiply by inv_std when scaling, else align by CF
    always_comb begin
        w_d_ext   = {{(PW-DW){r_s2_d[DW-1]}}, r_s2_d};
        w_inv_ext = {{(PW-CW){1'b0}}, r_s2_inv};
        w_s3_p    = w_d_ext <<< CF;
        if (r_s2_mode == MODE_SCL || r_s2_mode == MODE_CS)
            w_s3_p = w_d_ext * w_inv_ext;
    end

    // Output scaling floors toward minus infinity, then clamps to ZW bits
    assign w_s4_r       = r_s3_p >>> SH;
    assign w_sat        = sat_signed({{(64-PW){w_s4_r[PW-1]}}, w_s4_r}, ZW);
    assign w_unused_sat = &{1'b0, w_sat.val[63:ZW]};

    // Pipeline registers, all advancing together on the global enable
    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            r_s1_v    <= 1'b0;
            r_s1_x    <= '0;
            r_s1_ch   <= '0;
            r_s1_mode <= '0;
            r_s1_mean <= '0;
            r_s1_inv  <= '0;
            r_s2_v    <= 1'b0;
            r_s2_x    <= '0;
            r_s2_ch   <= '0;
            r_s2_mode <= '0;
            r_s2_d    <= '0;
            r_s2_inv  <= '0;
            r_s3_v    <= 1'b0;
            r_s3_x    <= '0;
            r_s3_ch   <= '0;
            r_s3_p    <= '0;
            out_valid <= 1'b0;
            out_z     <= '0;
            out_sat   <= 1'b0;
            out_ch    <= '0;
            out_x     <= '0;
        end else if (w_en) begin
            r_s1_v    <= in_valid;
            r_s1_x    <= in_x;
            r_s1_ch   <= in_ch;
            r_s1_mode <= in_mode;
            r_s1_mean <= w_mean;
            r_s1_inv  <= w_inv;
            r_s2_v    <= r_s1_v;
            r_s2_x    <= r_s1_x;
            r_s2_ch   <= r_s1_ch;
            r_s2_mode <= r_s1_mode;
            r_s2_d    <= w_s2_d;
            r_s2_inv  <= r_s1_inv;
            r_s3_v    <= r_s2_v;
            r_s3_x    <= r_s2_x;
            r_s3_ch   <= r_s2_ch;
            r_s3_p    <= w_s3_p;
            out_valid <= r_s3_v;
            out_z     <= w_sat.val[ZW-1:0];
            out_sat   <= w_sat.sat;
            out_ch    <= r_s3_ch;
            out_x     <= r_s3_x;
        end
    end

endmodule

// File: tb/tb_center_scale_mc.sv
// Self-checking bench for center_scale_mc: directed scenarios plus randomized
// traffic checked against an arithmetic reference model.
module tb_center_scale_mc;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        GlobalReset;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] in_x;
    logic [1:0]  in_ch;
    logic [1:0]  in_mode;
    logic        cfg_we;
    logic [1:0]  cfg_ch;
    logic        cfg_sel;
    logic [31:0] cfg_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic        out_sat;
    logic [1:0]  out_ch;
    logic [20:0] out_x;

    // result record: {z[31:0], sat, ch[1:0], x[20:0]}
    logic [55:0] exp_q[$];
    logic [55:0] got_q[$];
    longint      m_mean [NCH];
    longint      m_inv  [NCH];
    int          n_vec = 0;
    int          n_err = 0;

    center_scale_mc dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_ch       (in_ch),
        .in_mode     (in_mode),
        .cfg_we      (cfg_we),
        .cfg_ch      (cfg_ch),
        .cfg_sel     (cfg_sel),
        .cfg_data    (cfg_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_z       (out_z),
        .out_sat     (out_sat),
        .out_ch      (out_ch),
        .out_x       (out_x)
    );

    // clock
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic void model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_mean[i] = 0;
            m_inv[i]  = 65536;
        end
    endfunction

    // z = floor(((x*2^8) - mean) * inv / 2^8), clamped to signed 32 bits
    function automatic logic [55:0] ref_result(input logic [20:0] x, input logic [1:0] ch,
                                               input logic [1:0] mode);
        longint xl, mean, inv, d, p, r;
        logic [31:0] z;
        logic        sat;
        xl   = x;
        mean = (int'(ch) < NCH) ? m_mean[ch] : 0;
        inv  = (int'(ch) < NCH) ? m_inv[ch]  : 65536;
        d    = xl * 256;
        if (mode[0]) d = d - mean;
        if (mode[1]) p = d * inv;
        else         p = d * 65536;
        r = p >>> 8;
        sat = 1'b0;
        if (r > 64'sd2147483647) begin
            z = 32'h7FFFFFFF; sat = 1'b1;
        end else if (r < -64'sd2147483648) begin
            z = 32'h80000000; sat = 1'b1;
        end else begin
            z = r[31:0];
        end
        return {z, sat, ch, x};
    endfunction

    // ---------------- driver tasks ----------------
    // One clock: record accepts/transfers, apply cfg write to the model after
    // the accepted sample has taken its coefficients (old-value semantics).
    task automatic tick();
        #1;
        if (in_valid && in_ready) exp_q.push_back(ref_result(in_x, in_ch, in_mode));
        if (out_valid && out_ready) got_q.push_back({out_z, out_sat, out_ch, out_x});
        if (cfg_we && int'(cfg_ch) < NCH) begin
            if (cfg_sel) m_inv[cfg_ch]  = longint'(cfg_data[23:0]);
            else         m_mean[cfg_ch] = longint'(cfg_data[28:0]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        in_valid = 1'b0;
        cfg_we   = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] ch, input logic sel, input logic [31:0] data);
        cfg_we = 1'b1; cfg_ch = ch; cfg_sel = sel; cfg_data = data;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic send(input logic [20:0] x, input logic [1:0] ch, input logic [1:0] mode);
        in_valid = 1'b1; in_x = x; in_ch = ch; in_mode = mode;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        set_idle();
        out_ready = 1'b1;
        for (int i = 0; i < 80 && got_q.size() < exp_q.size(); i++) tick();
        tick();
    endtask

    task automatic clear_q();
        exp_q.delete();
        got_q.delete();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        GlobalReset = 1'b0;
        set_idle();
        out_ready = 1'b1; in_x = '0; in_ch = '0; in_mode = '0;
        cfg_ch = '0; cfg_sel = 1'b0; cfg_data = '0;
        model_reset();
        #23;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_vec++;
        if ({out_z, out_sat, out_ch, out_x} !== 56'd0) begin
            n_err++; $display("FAIL reset_out_fields got=%h exp=0", {out_z, out_sat, out_ch, out_x});
        end
        n_vec++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        GlobalReset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        clear_q();
        cfg_write(2'd0, 1'b0, 32'd100 << 8);
        cfg_write(2'd0, 1'b1, 32'h8000);
        send(21'h7F, 2'd0, 2'b11);
        tick();
        tick();
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
        tick();
        n_vec++;
        if (out_valid !== 1'b1) begin n_err++; $display("FAIL basic_latency got=%b exp=1", out_valid); end
        drain();
        n_vec++;
        if (got_q.size() != 1) begin
            n_err++; $display("FAIL basic_count got=%0d exp=1", got_q.size());
        end else begin
            n_vec++;
            if (got_q[0] !== {32'h000D8000, 1'b0, 2'd0, 21'h7F}) begin
                n_err++; $display("FAIL basic_result got=%h exp=%h", got_q[0], {32'h000D8000, 1'b0, 2'd0, 21'h7F});
            end
        end
    endtask

    task automatic test_mode_sweep();
        logic [31:0] z_tab [4];
        z_tab[0] = 32'h00090000;
        z_tab[1] = 32'hFFA50000;
        z_tab[2] = 32'h00048000;
        z_tab[3] = 32'hFFD28000;
        clear_q();
        for (int m = 0; m < 4; m++) begin
            in_valid = 1'b1; in_x = 21'd9; in_ch = 2'd0; in_mode = 2'(m);
            tick();
        end
        drain();
        n_vec++;
        if (got_q.size() != 4) begin n_err++; $display("FAIL sweep_count got=%0d exp=4", got_q.size()); end
        for (int m = 0; m < 4 && m < got_q.size(); m++) begin
            n_vec++;
            if (got_q[m] !== {z_tab[m], 1'b0, 2'd0, 21'd9}) begin
                n_err++; $display("FAIL sweep_mode%0d got=%h exp=%h", m, got_q[m], {z_tab[m], 1'b0, 2'd0, 21'd9});
            end
        end
    endtask

    task automatic test_saturation();
        logic [55:0] want [5];
        clear_q();
        cfg_write(2'd2, 1'b0, 32'd0);
        cfg_write(2'd2, 1'b1, 32'h00FFFFFF);
        cfg_write(2'd3, 1'b0, 32'h1FFFFFFF);
        cfg_write(2'd3, 1'b1, 32'h00FFFFFF);
        cfg_write(2'd1, 1'b0, 32'd0);
        cfg_write(2'd1, 1'b1, 32'd0);
        want[0] = {32'h7FFFFFFF, 1'b1, 2'd2, 21'h1FFFFF};
        want[1] = {32'h80000000, 1'b1, 2'd3, 21'h0};
        want[2] = {32'h80000000, 1'b1, 2'd3, 21'h0};
        want[3] = {32'h00000000, 1'b0, 2'd1, 21'h1234};
        want[4] = {32'h00000000, 1'b0, 2'd1, 21'h1234};
        send(21'h1FFFFF, 2'd2, 2'b11);
        send(21'h0, 2'd3, 2'b11);
        send(21'h0, 2'd3, 2'b01);
        send(21'h1234, 2'd1, 2'b10);
        send(21'h1234, 2'd1, 2'b11);
        drain();
        n_vec++;
        if (got_q.size() != 5) begin n_err++; $display("FAIL sat_count got=%0d exp=5", got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== want[i]) begin
                n_err++; $display("FAIL sat_case%0d got=%h exp=%h", i, got_q[i], want[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [55:0] snap;
        logic        stalled;
        clear_q();
        for (int t = 0; t < 60 && !(exp_q.size() >= 8 && got_q.size() >= 8); t++) begin
            out_ready = !(t >= 3 && t <= 7);
            in_valid  = (exp_q.size() < 8);
            in_x      = 21'($urandom_range(0, 21'h1FFFFF));
            in_ch     = 2'($urandom_range(0, 3));
            in_mode   = 2'($urandom_range(0, 3));
            #1;
            stalled = out_valid && !out_ready;
            snap    = {out_z, out_sat, out_ch, out_x};
            if (stalled) begin
                n_vec++;
                if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready t=%0d got=%b exp=0", t, in_ready); end
            end
            tick();
            if (stalled) begin
                n_vec++;
                if (out_valid !== 1'b1 || {out_z, out_sat, out_ch, out_x} !== snap) begin
                    n_err++; $display("FAIL bp_hold t=%0d got=%b/%h exp=1/%h", t, out_valid,
                                      {out_z, out_sat, out_ch, out_x}, snap);
                end
            end
        end
        drain();
        n_vec++;
        if (got_q.size() != 8 || exp_q.size() != 8) begin
            n_err++; $display("FAIL bp_count got=%0d exp=8 (sent %0d)", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL bp_order[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_coef_race();
        clear_q();
        cfg_write(2'd1, 1'b0, 32'd10 << 8);
        cfg_write(2'd1, 1'b1, 32'h10000);
        cfg_we = 1'b1; cfg_ch = 2'd1; cfg_sel = 1'b0; cfg_data = 32'd20 << 8;
        in_valid = 1'b1; in_x = 21'd50; in_ch = 2'd1; in_mode = 2'b01;
        tick();
        cfg_we = 1'b0;
        tick();
        drain();
        n_vec++;
        if (got_q.size() != 2) begin
            n_err++; $display("FAIL race_count got=%0d exp=2", got_q.size());
        end else begin
            n_vec++;
            if (got_q[0] !== {32'h00280000, 1'b0, 2'd1, 21'd50}) begin
                n_err++; $display("FAIL race_old_mean got=%h exp=%h", got_q[0], {32'h00280000, 1'b0, 2'd1, 21'd50});
            end
            n_vec++;
            if (got_q[1] !== {32'h001E0000, 1'b0, 2'd1, 21'd50}) begin
                n_err++; $display("FAIL race_new_mean got=%h exp=%h", got_q[1], {32'h001E0000, 1'b0, 2'd1, 21'd50});
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_q();
        cfg_write(2'd0, 1'b0, 32'($urandom_range(0, 32'h1FFFFFFF)));
        cfg_write(2'd0, 1'b1, 32'($urandom_range(0, 32'h3FFFF)));
        cfg_write(2'd1, 1'b0, 32'($urandom_range(0, 32'h1FFFFFFF)));
        cfg_write(2'd1, 1'b1, 32'($urandom_range(32'h40000, 32'hFFFFFF)));
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1; in_x = 21'($urandom_range(0, 21'h1FFFFF));
            in_ch = 2'(i % 2); in_mode = 2'b11;
            tick();
        end
        drain();
        n_vec++;
        if (got_q.size() != 16) begin n_err++; $display("FAIL b2b_count got=%0d exp=16", got_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL b2b[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        clear_q();
        for (int t = 0; t < 400; t++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_x      = 21'($urandom_range(0, 21'h1FFFFF));
            in_ch     = 2'($urandom_range(0, 3));
            in_mode   = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 4) != 0);
            cfg_we    = ($urandom_range(0, 7) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_sel   = 1'($urandom_range(0, 1));
            cfg_data  = cfg_sel ? 32'($urandom_range(0, 32'h1FFFF)) : $urandom;
            tick();
        end
        drain();
        n_vec++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL rand_count got=%0d exp=%0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            n_vec++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL rand[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        clear_q();
        cfg_write(2'd0, 1'b0, 32'd77 << 8);
        cfg_write(2'd0, 1'b1, 32'h3000);
        cfg_write(2'd2, 1'b0, 32'd5 << 8);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_x = 21'(100 + i); in_ch = 2'd0; in_mode = 2'b11;
            tick();
        end
        set_idle();
        #2;
        GlobalReset = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        n_vec++;
        if ({out_z, out_sat, out_ch, out_x} !== 56'd0) begin
            n_err++; $display("FAIL midrst_fields got=%h exp=0", {out_z, out_sat, out_ch, out_x});
        end
        model_reset();
        clear_q();
        @(negedge clk);
        GlobalReset = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_stale[%0d] got=%b exp=0", i, out_valid); end
        end
        send(21'd5, 2'd0, 2'b11);
        send(21'd5, 2'd2, 2'b11);
        drain();
        n_vec++;
        if (got_q.size() != 2) begin
            n_err++; $display("FAIL midrst_count got=%0d exp=2", got_q.size());
        end else begin
            n_vec++;
            if (got_q[0] !== {32'h00050000, 1'b0, 2'd0, 21'd5}) begin
                n_err++; $display("FAIL midrst_coef_ch0 got=%h exp=%h", got_q[0], {32'h00050000, 1'b0, 2'd0, 21'd5});
            end
            n_vec++;
            if (got_q[1] !== {32'h00050000, 1'b0, 2'd2, 21'd5}) begin
                n_err++; $display("FAIL midrst_coef_ch2 got=%h exp=%h", got_q[1], {32'h00050000, 1'b0, 2'd2, 21'd5});
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_mode_sweep();
        test_saturation();
        test_backpressure();
        test_coef_race();
        test_back_to_back();
        test_random();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
